// File: rtl/rsa_job_arbiter.sv
// Round-robin arbiter that shares one rsa4k engine among NUM_REQ job sources.
// It latches the winning requester's operands, sequences the engine and returns the result over valid/ready.
`timescale 1ns/1ps
module rsa_job_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int          RSA_WIDTH      = 4096,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
    parameter int          RST_CYCLES     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*RSA_WIDTH-1:0] req_message,
    input  logic [NUM_REQ*RSA_WIDTH-1:0] req_exponent,
    input  logic [NUM_REQ*RSA_WIDTH-1:0] req_modulus,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [RSA_WIDTH-1:0]         rsp_data,
    output logic                         rsp_error,
    output logic                         busy,
    output logic                         eng_reset,
    output logic                         eng_go,
    output logic [RSA_WIDTH-1:0]         eng_message,
    output logic [RSA_WIDTH-1:0]         eng_exponent,
    output logic [RSA_WIDTH-1:0]         eng_modulus,
    input  logic [RSA_WIDTH-1:0]         eng_cypher,
    input  logic                         eng_done
);

    localparam int          PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 32'd1;
    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ENG_RST,
        IDLE,
        ISSUE,
        WAIT_CLR,
        WAIT_DONE,
        RESP
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;
    logic [PW-1:0] winner;
    logic [PW-1:0] next_ptr;
    logic          found;
    logic [31:0]   rst_cnt;
    logic [31:0]   tmo_cnt;

    // Rotated-priority search: the first requester at or after ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        next_ptr = PW'((int'(winner) + 1) % NUM_REQ);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ENG_RST;
            ptr          <= '0;
            gnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
            eng_reset    <= 1'b1;
            eng_go       <= 1'b0;
            eng_message  <= '0;
            eng_exponent <= '0;
            eng_modulus  <= '0;
            rst_cnt      <= '0;
            tmo_cnt      <= '0;
        end else begin
            eng_go <= 1'b0;
            case (state)
                ENG_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        eng_reset <= 1'b0;
                        rst_cnt   <= '0;
                        state     <= IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + 32'd1;
                    end
                end
                IDLE: begin
                    if (found) begin
                        gnt          <= NUM_REQ'(1) << winner;
                        eng_message  <= req_message[int'(winner)*RSA_WIDTH +: RSA_WIDTH];
                        eng_exponent <= req_exponent[int'(winner)*RSA_WIDTH +: RSA_WIDTH];
                        eng_modulus  <= req_modulus[int'(winner)*RSA_WIDTH +: RSA_WIDTH];
                        ptr          <= next_ptr;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    eng_go  <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= WAIT_CLR;
                end
                // A done still high here belongs to the previous job, so only the timeout can end this wait.
                WAIT_CLR: begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                    if (tmo_cnt == TMO_LAST) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (!eng_done) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                    if (eng_done) begin
                        rsp_data  <= eng_cypher;
                        rsp_error <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_error <= 1'b0;
                        gnt       <= '0;
                        if (rsp_error) begin
                            eng_reset <= 1'b1;
                            rst_cnt   <= '0;
                            state     <= ENG_RST;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= ENG_RST;
            endcase
        end
    end

endmodule
